atom_rv_core_alu: RTL and testbench

Execute-stage arithmetic/logic unit of the atomRVCORE single-issue RV32 core. It sits between the decoder and the data-memory/write-back path. It takes two 32-bit operands, a 6-bit operation code and the instruction's PC from the decoder. It returns a registered result and a registered copy of the PC, one cycle later. The result feeds register write-back and the branch decision, aligned with the destination register that the data-memory stage pipelines by one cycle.

---
 rtl/atom_rv_core_alu_pkg.sv | 37 +++
 rtl/atom_rv_core_alu_if.sv | 22 ++
 rtl/atom_rv_core_muldiv.sv | 57 +++++
 rtl/atom_rv_core_alu.sv | 86 ++++++++
 tb/tb_atom_rv_core_alu.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/atom_rv_core_alu_pkg.sv
// rtl/atom_rv_core_alu_pkg.sv - shared ALU widths and op-code enum (atom_rv_core_pkg)
package atom_rv_core_pkg;

    localparam int DATAWIDTH = 32;
    localparam int ALU_OP    = 6;

    typedef enum logic [5:0] {
        OP_ADD    = 6'h00,
        OP_SUB    = 6'h01,
        OP_SLL    = 6'h02,
        OP_SLT    = 6'h03,
        OP_SLTU   = 6'h04,
        OP_XOR    = 6'h05,
        OP_SRL    = 6'h06,
        OP_SRA    = 6'h07,
        OP_OR     = 6'h08,
        OP_AND    = 6'h09,
        OP_BEQ    = 6'h10,
        OP_BNE    = 6'h11,
        OP_BLT    = 6'h12,
        OP_BGE    = 6'h13,
        OP_BLTU   = 6'h14,
        OP_BGEU   = 6'h15,
        OP_PASSB  = 6'h18,
        OP_LINK   = 6'h19,
        OP_AUIPC  = 6'h1A,
        OP_MUL    = 6'h20,
        OP_MULH   = 6'h21,
        OP_MULHSU = 6'h22,
        OP_MULHU  = 6'h23,
        OP_DIV    = 6'h24,
        OP_DIVU   = 6'h25,
        OP_REM    = 6'h26,
        OP_REMU   = 6'h27
    } alu_op_e;

endpackage

// File: rtl/atom_rv_core_alu_if.sv
// rtl/atom_rv_core_alu_if.sv - decoder-to-ALU operand/result bundle with modports
interface atom_rv_core_alu_if #(
    parameter int DATAWIDTH = atom_rv_core_pkg::DATAWIDTH,
    parameter int ALU_OP    = atom_rv_core_pkg::ALU_OP
);
    logic [ALU_OP-1:0]    ALUop_i;
    logic [DATAWIDTH-1:0] operand_A;
    logic [DATAWIDTH-1:0] operand_B;
    logic [DATAWIDTH-1:0] PC_i;
    logic [DATAWIDTH-1:0] result_o;
    logic [DATAWIDTH-1:0] PC_o;

    modport master (
        output ALUop_i, operand_A, operand_B, PC_i,
        input  result_o, PC_o
    );

    modport slave (
        input  ALUop_i, operand_A, operand_B, PC_i,
        output result_o, PC_o
    );
endinterface

// File: rtl/atom_rv_core_muldiv.sv
// rtl/atom_rv_core_muldiv.sv - combinational RV32M unit, present only with ATOM_RV_CORE_ALU_MULDIV_EN
`ifdef ATOM_RV_CORE_ALU_MULDIV_EN
module atom_rv_core_muldiv #(
    parameter int W = 32
) (
    input  logic [5:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o
);
    import atom_rv_core_pkg::*;

    logic         a_sx, b_sx;
    logic [2*W-1:0] a_ext, b_ext, prod;
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag, mag_q, mag_r, u_q, u_r, s_q, s_r;

    // One shared 2W-bit multiplier; operand extension selects the signedness flavour
    always_comb begin
        a_sx  = (op_i == OP_MULH) || (op_i == OP_MULHSU);
        b_sx  = (op_i == OP_MULH);
        a_ext = {{W{a_sx & a_i[W-1]}}, a_i};
        b_ext = {{W{b_sx & b_i[W-1]}}, b_i};
        prod  = a_ext * b_ext;
    end

    // Signed division via magnitudes so MIN/-1 wraps naturally to MIN with remainder 0
    always_comb begin
        a_neg = a_i[W-1];
        b_neg = b_i[W-1];
        a_mag = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag = b_neg ? (~b_i + 1'b1) : b_i;
        mag_q = a_mag / b_mag;
        mag_r = a_mag % b_mag;
        s_q   = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
        s_r   = a_neg ? (~mag_r + 1'b1) : mag_r;
        u_q   = a_i / b_i;
        u_r   = a_i % b_i;
    end

    // Result select; a zero divisor overrides the quotient/remainder datapath
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_MUL:    result_o = prod[W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  result_o = prod[2*W-1:W];
            OP_DIV:    result_o = (b_i == '0) ? '1  : s_q;
            OP_DIVU:   result_o = (b_i == '0) ? '1  : u_q;
            OP_REM:    result_o = (b_i == '0) ? a_i : s_r;
            OP_REMU:   result_o = (b_i == '0) ? a_i : u_r;
            default:   result_o = '0;
        endcase
    end
endmodule
`endif

// File: rtl/atom_rv_core_alu.sv
// rtl/atom_rv_core_alu.sv - single-cycle registered execute ALU; RV32M under ATOM_RV_CORE_ALU_MULDIV_EN
module atom_rv_core_alu #(
    parameter int DATAWIDTH = atom_rv_core_pkg::DATAWIDTH,
    parameter int ALU_OP    = atom_rv_core_pkg::ALU_OP
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    atom_rv_core_alu_if.slave       alu_if
);
    import atom_rv_core_pkg::*;

    localparam int SHW = $clog2(DATAWIDTH);

    logic [ALU_OP-1:0]    op;
    logic [DATAWIDTH-1:0] a, b, pc;
    logic [SHW-1:0]       shamt;
    logic                 lt_s, lt_u, eq;
    logic [DATAWIDTH-1:0] result_d, result_q, pc_d, pc_q;

    assign op    = alu_if.ALUop_i;
    assign a     = alu_if.operand_A;
    assign b     = alu_if.operand_B;
    assign pc    = alu_if.PC_i;
    assign shamt = b[SHW-1:0];

`ifdef ATOM_RV_CORE_ALU_MULDIV_EN
    logic [DATAWIDTH-1:0] md_result;

    atom_rv_core_muldiv #(.W(DATAWIDTH)) u_muldiv (
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (md_result)
    );
`endif

    // Next result: one combinational evaluation of the selected operation
    always_comb begin
        lt_s     = $signed(a) < $signed(b);
        lt_u     = a < b;
        eq       = (a == b);
        result_d = '0;
        case (op)
            OP_ADD:   result_d = a + b;
            OP_SUB:   result_d = a - b;
            OP_SLL:   result_d = a << shamt;
            OP_SRL:   result_d = a >> shamt;
            OP_SRA:   result_d = $unsigned($signed(a) >>> shamt);
            OP_SLT:   result_d = DATAWIDTH'(lt_s);
            OP_SLTU:  result_d = DATAWIDTH'(lt_u);
            OP_XOR:   result_d = a ^ b;
            OP_OR:    result_d = a | b;
            OP_AND:   result_d = a & b;
            OP_BEQ:   result_d = DATAWIDTH'(eq);
            OP_BNE:   result_d = DATAWIDTH'(!eq);
            OP_BLT:   result_d = DATAWIDTH'(lt_s);
            OP_BGE:   result_d = DATAWIDTH'(!lt_s);
            OP_BLTU:  result_d = DATAWIDTH'(lt_u);
            OP_BGEU:  result_d = DATAWIDTH'(!lt_u);
            OP_PASSB: result_d = b;
            OP_LINK:  result_d = pc + DATAWIDTH'(4);
            OP_AUIPC: result_d = pc + b;
`ifdef ATOM_RV_CORE_ALU_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                      result_d = md_result;
`endif
            default:  result_d = '0;
        endcase
        pc_d = pc;
    end

    // Output registers; reset wins over any operation presented in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            pc_q     <= '0;
        end else begin
            result_q <= result_d;
            pc_q     <= pc_d;
        end
    end

    assign alu_if.result_o = result_q;
    assign alu_if.PC_o     = pc_q;
endmodule

// File: tb/tb_atom_rv_core_alu.sv
// tb/tb_atom_rv_core_alu.sv - directed vector bench for atom_rv_core_alu
module tb_atom_rv_core_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    atom_rv_core_alu_if bus ();

    atom_rv_core_alu dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .alu_if (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic [5:0] op, logic [31:0] a,
                                logic [31:0] b, logic [31:0] pc, logic [31:0] exp);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.pc = pc; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] pc);
        bus.ALUop_i   = op;
        bus.operand_A = a;
        bus.operand_B = b;
        bus.PC_i      = pc;
    endtask

    initial begin
        add("add_wrap",  6'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,   32'h0);
        add("sub_wrap",  6'h01, 32'h0,         32'h1,         32'h4,   32'hFFFF_FFFF);
        add("sra",       6'h07, 32'h8000_0000, 32'h21,        32'h8,   32'hC000_0000);
        add("srl",       6'h06, 32'h8000_0000, 32'h21,        32'hC,   32'h4000_0000);
        add("sll",       6'h02, 32'h1,         32'h24,        32'h10,  32'h10);
        add("slt",       6'h03, 32'hFFFF_FFFF, 32'h1,         32'h14,  32'h1);
        add("sltu",      6'h04, 32'hFFFF_FFFF, 32'h1,         32'h18,  32'h0);
        add("blt",       6'h12, 32'hFFFF_FFFF, 32'h1,         32'h1C,  32'h1);
        add("bgeu",      6'h15, 32'hFFFF_FFFF, 32'h1,         32'h20,  32'h1);
        add("bge",       6'h13, 32'hFFFF_FFFF, 32'h1,         32'h24,  32'h0);
        add("bltu",      6'h14, 32'hFFFF_FFFF, 32'h1,         32'h28,  32'h0);
        add("beq",       6'h10, 32'h9,         32'h9,         32'h2C,  32'h1);
        add("bne",       6'h11, 32'h9,         32'h9,         32'h30,  32'h0);
        add("xor",       6'h05, 32'hF0F0,      32'hFF00,      32'h34,  32'h0FF0);
        add("or",        6'h08, 32'hF0F0,      32'hFF00,      32'h38,  32'hFFF0);
        add("and",       6'h09, 32'hF0F0,      32'hFF00,      32'h3C,  32'hF000);
        add("link",      6'h19, 32'h5,         32'h6,         32'h100, 32'h104);
        add("auipc",     6'h1A, 32'h5,         32'h1000,      32'h100, 32'h1100);
        add("passb",     6'h18, 32'h5,         32'hABCD_E000, 32'h100, 32'hABCD_E000);
        add("unlisted",  6'h3F, 32'h1234,      32'h5678,      32'h200, 32'h0);
`ifdef ATOM_RV_CORE_ALU_MULDIV_EN
        add("mul",       6'h20, 32'h3,         32'h4,         32'h300, 32'hC);
        add("mulh",      6'h21, 32'h8000_0000, 32'h8000_0000, 32'h304, 32'h4000_0000);
        add("mulhu",     6'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h308, 32'hFFFF_FFFE);
        add("mulhsu",    6'h22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h30C, 32'hFFFF_FFFF);
        add("div_by0",   6'h24, 32'h7,         32'h0,         32'h310, 32'hFFFF_FFFF);
        add("divu_by0",  6'h25, 32'h7,         32'h0,         32'h314, 32'hFFFF_FFFF);
        add("rem_by0",   6'h26, 32'h7,         32'h0,         32'h318, 32'h7);
        add("remu_by0",  6'h27, 32'h7,         32'h0,         32'h31C, 32'h7);
        add("div_ovf",   6'h24, 32'h8000_0000, 32'hFFFF_FFFF, 32'h320, 32'h8000_0000);
        add("rem_ovf",   6'h26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h324, 32'h0);
        add("rem_neg",   6'h26, 32'hFFFF_FFF9, 32'h2,         32'h328, 32'hFFFF_FFFF);
        add("div_neg",   6'h24, 32'hFFFF_FFF9, 32'h2,         32'h32C, 32'hFFFF_FFFD);
`else
        add("mul_off",   6'h20, 32'h3,         32'h4,         32'h300, 32'h0);
        add("div_off",   6'h24, 32'h7,         32'h0,         32'h304, 32'h0);
`endif

        // Reset with an ADD pending: outputs must stay cleared
        drive(6'h00, 32'd5, 32'd7, 32'h40);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_result", bus.result_o, 32'h0);
        check("rst_pc",     bus.PC_o,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_result", bus.result_o, 32'd12);
        check("post_rst_pc",     bus.PC_o,     32'h40);

        // Back-to-back vectors: a new op every cycle, each checked one edge later
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc);
            @(posedge clk); #1;
            check(vecs[i].name, bus.result_o, vecs[i].exp);
            check({vecs[i].name, "_pc"}, bus.PC_o, vecs[i].pc);
        end

        // Outputs hold between edges while inputs change
        @(negedge clk);
        drive(6'h00, 32'd1, 32'd2, 32'h500);
        @(posedge clk); #1;
        drive(6'h01, 32'd10, 32'd3, 32'h504);
        #2;
        check("hold_result", bus.result_o, 32'd3);
        check("hold_pc",     bus.PC_o,     32'h500);
        @(posedge clk); #1;
        check("next_result", bus.result_o, 32'd7);

        // Mid-stream reset clears, then one released edge reloads
        @(negedge clk);
        rst = 1'b1;
        drive(6'h18, 32'h0, 32'hDEAD_BEEF, 32'h600);
        @(posedge clk); #1;
        check("mid_rst_result", bus.result_o, 32'h0);
        check("mid_rst_pc",     bus.PC_o,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rel_result", bus.result_o, 32'hDEAD_BEEF);
        check("mid_rel_pc",     bus.PC_o,     32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
